// File: rtl/ifetch_queue.sv
// In-order instruction fetch queue: request/response imem port, several fetches in flight,
// flush and re-steer on redirect. Define IFETCH_ERR_HALT_EN to record faults and halt issue.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_insn_valid,
    input  logic        i_insn_ready,
    output logic [31:0] o_insn,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_incr,
    output logic        o_insn_err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          run_q;

    logic [31:0] insn_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic [PW-1:0] occupancy;
    logic [PW-1:0] outstanding;
    logic [SW-1:0] budget;
    logic          halt;
    logic          req_valid;
    logic          req_fire;
    logic          insn_valid;
    logic          pop;
    logic          rsp_keep;

    assign occupancy   = alloc_q - rd_q;
    assign outstanding = alloc_q - fill_q;
    // Dropped-but-pending responses still hold a slot so old-stream data cannot overflow.
    assign budget      = SW'(occupancy) + SW'(drop_q);

    assign req_valid  = run_q && !halt && !i_redirect_valid && (budget < SW'(DEPTH));
    assign req_fire   = req_valid && i_imem_req_ready;
    assign insn_valid = (fill_q != rd_q);
    assign pop        = insn_valid && i_insn_ready;
    assign rsp_keep   = i_imem_rsp_valid && (drop_q == '0) && !i_redirect_valid;

`ifdef IFETCH_ERR_HALT_EN
    logic halt_q, halt_d;
    logic err_mem_q [DEPTH];
    logic [1:0] unused_pc_lsb;

    assign halt          = halt_q;
    assign unused_pc_lsb = i_redirect_pc[1:0];

    always_comb begin
        halt_d = halt_q;
        if (i_redirect_valid) begin
            halt_d = 1'b0;
        end else if (rsp_keep && i_imem_rsp_err) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halt_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                err_mem_q[i] <= 1'b0;
            end
        end else begin
            halt_q <= halt_d;
            if (rsp_keep) begin
                err_mem_q[fill_q[AW-1:0]] <= i_imem_rsp_err;
            end
        end
    end

    assign o_insn_err = err_mem_q[rd_q[AW-1:0]];
`else
    logic [2:0] unused_inputs;

    assign halt          = 1'b0;
    assign unused_inputs = {i_imem_rsp_err, i_redirect_pc[1:0]};
    assign o_insn_err    = 1'b0;
`endif

    always_comb begin
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        if (i_redirect_valid) begin
            // A response landing this cycle belongs to the old stream, hence the subtraction.
            alloc_d    = alloc_q;
            fill_d     = alloc_q;
            rd_d       = alloc_q;
            drop_d     = drop_q + outstanding - PW'(i_imem_rsp_valid);
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
        end else begin
            if (req_fire) begin
                alloc_d    = alloc_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (i_imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - PW'(1);
                end else begin
                    fill_d = fill_q + PW'(1);
                end
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                insn_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            if (req_fire) begin
                pc_mem_q[alloc_q[AW-1:0]] <= fetch_pc_q;
            end
            if (rsp_keep) begin
                insn_mem_q[fill_q[AW-1:0]] <= i_imem_rsp_data;
            end
        end
    end

    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = fetch_pc_q;
    assign o_insn_valid     = insn_valid;
    assign o_insn           = insn_mem_q[rd_q[AW-1:0]];
    assign o_pc             = pc_mem_q[rd_q[AW-1:0]];
    assign o_pc_incr        = o_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: in-order imem model with variable latency, and a
// stream-level reference (expected PC sequence per redirect epoch, slot accounting).
module tb_ifetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] pc_incr;
    logic        insn_err;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_imem_rsp_err   (imem_rsp_err),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_insn_valid     (insn_valid),
        .i_insn_ready     (insn_ready),
        .o_insn           (insn),
        .o_pc             (pc),
        .o_pc_incr        (pc_incr),
        .o_insn_err       (insn_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        imq[$];     // accepted, not yet answered (any epoch)
    bit          held_q[$];  // err bits of current-epoch words buffered, not yet consumed
    int          cyc = 0;
    int          epoch = 0;
    int          checks = 0;
    int          errors = 0;
    int          req_count = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    bit          run_m = 1'b0;
    bit          halt_m = 1'b0;

    int          p_req_rdy = 100;
    int          p_rsp = 100;
    int          p_insn_rdy = 100;
    int          p_redir = 0;    // per mille
    int          lat_min = 1;
    int          lat_max = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit          redir;
        bit          rsp_fire;
        bit          exp_req;
        logic [31:0] rpc;
        req_t        r;
        @(negedge clk);
        imem_req_ready = ($urandom_range(99) < p_req_rdy);
        insn_ready     = ($urandom_range(99) < p_insn_rdy);
        redir          = force_redir || (int'($urandom_range(999)) < p_redir);
        case ($urandom_range(3))
            0:       rpc = 32'hFFFF_FFF8 | 32'($urandom_range(3));
            1:       rpc = $urandom;
            default: rpc = 32'($urandom_range(1023));
        endcase
        if (force_redir) rpc = force_pc;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp_fire = (imq.size() > 0) && (imq[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rsp_fire;
        imem_rsp_data  = rsp_fire ? word_of(imq[0].addr) : $urandom;
        imem_rsp_err   = ($urandom_range(15) == 0);
        #1;
        check_eq("insn_valid", insn_valid, 32'(held_q.size() > 0));
        exp_req = run_m && !halt_m && !redir && (imq.size() + held_q.size() < DEPTH);
        check_eq("req_valid", imem_req_valid, 32'(exp_req));
        if (exp_req) check_eq("req_addr", imem_req_addr, exp_fetch);
        if (held_q.size() > 0) begin
            check_eq("head_pc", pc, exp_pc);
            check_eq("head_insn", insn, word_of(exp_pc));
            check_eq("head_pc_incr", pc_incr, exp_pc + 32'd4);
`ifdef IFETCH_ERR_HALT_EN
            check_eq("head_err", insn_err, 32'(held_q[0]));
`else
            check_eq("head_err", insn_err, 32'd0);
`endif
            if (insn_ready) begin
                void'(held_q.pop_front());
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rsp_fire) begin
            r = imq.pop_front();
            if (!redir && r.epoch == epoch) begin
`ifdef IFETCH_ERR_HALT_EN
                held_q.push_back(imem_rsp_err);
                if (imem_rsp_err) halt_m = 1'b1;
`else
                held_q.push_back(1'b0);
`endif
            end
        end
        if (exp_req && imem_req_ready) begin
            r.addr  = exp_fetch;
            r.due   = cyc + int'($urandom_range(lat_max, lat_min));
            r.epoch = epoch;
            imq.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
            req_count++;
        end
        if (redir) begin
            epoch++;
            held_q.delete();
            exp_pc    = {rpc[31:2], 2'b00};
            exp_fetch = {rpc[31:2], 2'b00};
            halt_m    = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        insn_ready     = 1'b0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_insn_valid", insn_valid, 32'd0);
        check_eq("rst_insn", insn, 32'd0);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_pc_incr", pc_incr, 32'd4);
        check_eq("rst_insn_err", insn_err, 32'd0);
        imq.delete();
        held_q.delete();
        epoch++;
        run_m     = 1'b0;
        halt_m    = 1'b0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("run_delay_req_valid", imem_req_valid, 32'd0);
        check_eq("run_delay_req_addr", imem_req_addr, RESET_PC);
        run_m = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        force_redir = 1'b1;
        force_pc    = target;
        step();
        force_redir = 1'b0;
    endtask

    initial begin
        do_reset();

        // Backpressure: consumer stalled, single-cycle imem; only DEPTH fetches may issue.
        p_insn_rdy = 0;
        req_count  = 0;
        repeat (10) step();
        check_eq("bp_req_count", req_count, DEPTH);
        p_insn_rdy = 100;
        repeat (20) step();

        // Redirect while responses are in flight on a 3-cycle imem.
        lat_min = 3;
        lat_max = 3;
        repeat (6) step();
        redirect_to(32'h0000_0100);
        repeat (20) step();

        // PC wrap through 0xFFFF_FFFC.
        lat_min = 1;
        lat_max = 1;
        redirect_to(32'hFFFF_FFF8);
        repeat (12) step();

        // Randomized traffic.
        p_req_rdy  = 70;
        p_rsp      = 70;
        p_insn_rdy = 60;
        p_redir    = 20;
        lat_min    = 1;
        lat_max    = 4;
        repeat (4000) step();

        // Reset in the middle of traffic, then resume.
        do_reset();
        repeat (600) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
